fft_bitrev_reorder: RTL and testbench

//  Output reorder stage of the FFT_R2SDF pipeline; consumes the stream written by the last SDF stage.
//  R2SDF results leave the pipeline in bit-reversed order; this block returns them to natural order.

---
 rtl/fft_bitrev_reorder_if.sv | 34 +++
 rtl/fft_bitrev_reorder.sv | 166 ++++++++++++++++
 tb/tb_fft_bitrev_reorder.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/fft_bitrev_reorder_if.sv
// Stream bundle between the last R2SDF stage and the bit-reversal reorder buffer.
// Optional frame markers oSof/oEof exist only when FFT_REORDER_FRAME_EN is defined.
interface fft_bitrev_reorder_if #(
    parameter int DATA_W = 38
);
    logic              iEn;
    logic [DATA_W-1:0] iData_Re;
    logic [DATA_W-1:0] iData_Im;
    logic              oValid;
    logic [DATA_W-1:0] oData_Re;
    logic [DATA_W-1:0] oData_Im;
`ifdef FFT_REORDER_FRAME_EN
    logic              oSof;
    logic              oEof;

    modport master (
        output iEn, iData_Re, iData_Im,
        input  oValid, oData_Re, oData_Im, oSof, oEof
    );
    modport slave (
        input  iEn, iData_Re, iData_Im,
        output oValid, oData_Re, oData_Im, oSof, oEof
    );
`else
    modport master (
        output iEn, iData_Re, iData_Im,
        input  oValid, oData_Re, oData_Im
    );
    modport slave (
        input  iEn, iData_Re, iData_Im,
        output oValid, oData_Re, oData_Im
    );
`endif
endinterface

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: frames arrive in bit-reversed order and leave in natural order.
// Optional feature macro FFT_REORDER_FRAME_EN adds registered oSof/oEof frame markers.
module fft_bitrev_reorder #(
    parameter int DATA_W = 38,
    parameter int LOG2N  = 4
) (
    input  logic                  iClk,
    input  logic                  iRst,
    fft_bitrev_reorder_if.slave   bus
);
    localparam int                 N        = 1 << LOG2N;
    localparam logic [LOG2N-1:0]   CNT_LAST = {LOG2N{1'b1}};
    localparam logic [LOG2N-1:0]   CNT_ZERO = {LOG2N{1'b0}};
    localparam logic [LOG2N-1:0]   CNT_ONE  = {{(LOG2N-1){1'b0}}, 1'b1};

    typedef enum logic {
        S_IDLE = 1'b0,
        S_READ = 1'b1
    } state_t;

    function automatic logic [LOG2N-1:0] f_bitrev(input logic [LOG2N-1:0] k);
        logic [LOG2N-1:0] r;
        for (int b = 0; b < LOG2N; b++) begin
            r[b] = k[LOG2N-1-b];
        end
        return r;
    endfunction

    // Bank select is the MSB of the RAM address.
    logic [2*DATA_W-1:0] r_mem [0:2*N-1];

    logic [LOG2N-1:0]    r_wr_cnt;
    logic                r_wr_bank;
    logic [LOG2N-1:0]    r_rd_cnt;
    logic                r_rd_bank;
    state_t              r_state;
    logic                r_valid;
    logic [DATA_W-1:0]   r_re;
    logic [DATA_W-1:0]   r_im;

    state_t              w_state_nxt;
    logic [LOG2N-1:0]    w_rd_cnt_nxt;
    logic                w_rd_bank_nxt;
    logic                w_rd_en;
    logic                w_frame_done;
    logic [LOG2N:0]      w_rd_addr;
    logic [2*DATA_W-1:0] w_rd_word;

    assign w_frame_done = bus.iEn & (r_wr_cnt == CNT_LAST);
    assign w_rd_addr    = {r_rd_bank, f_bitrev(r_rd_cnt)};
    assign w_rd_word    = r_mem[w_rd_addr];

    // Write pointer: advances per captured sample, flips bank at end of frame.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_wr_cnt  <= CNT_ZERO;
            r_wr_bank <= 1'b0;
        end else if (bus.iEn) begin
            if (w_frame_done) begin
                r_wr_cnt  <= CNT_ZERO;
                r_wr_bank <= ~r_wr_bank;
            end else begin
                r_wr_cnt  <= r_wr_cnt + CNT_ONE;
            end
        end
    end

    // Frame RAM, written in arrival order; contents deliberately not reset.
    always_ff @(posedge iClk) begin
        if (bus.iEn) begin
            r_mem[{r_wr_bank, r_wr_cnt}] <= {bus.iData_Re, bus.iData_Im};
        end
    end

    // Read FSM state and read pointer registers.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_state   <= S_IDLE;
            r_rd_cnt  <= CNT_ZERO;
            r_rd_bank <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rd_cnt  <= w_rd_cnt_nxt;
            r_rd_bank <= w_rd_bank_nxt;
        end
    end

    // Read FSM next state; a frame completing on the last read chains straight on.
    always_comb begin
        w_state_nxt   = r_state;
        w_rd_cnt_nxt  = r_rd_cnt;
        w_rd_bank_nxt = r_rd_bank;
        w_rd_en       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_frame_done) begin
                    w_state_nxt   = S_READ;
                    w_rd_cnt_nxt  = CNT_ZERO;
                    w_rd_bank_nxt = r_wr_bank;
                end else begin
                    w_state_nxt   = S_IDLE;
                end
            end
            S_READ: begin
                w_rd_en = 1'b1;
                if (r_rd_cnt == CNT_LAST) begin
                    w_rd_cnt_nxt = CNT_ZERO;
                    if (w_frame_done) begin
                        w_state_nxt   = S_READ;
                        w_rd_bank_nxt = r_wr_bank;
                    end else begin
                        w_state_nxt   = S_IDLE;
                    end
                end else begin
                    w_rd_cnt_nxt = r_rd_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_rd_cnt_nxt = CNT_ZERO;
            end
        endcase
    end

    // Output register: data holds its last value while idle.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_valid <= 1'b0;
            r_re    <= {DATA_W{1'b0}};
            r_im    <= {DATA_W{1'b0}};
        end else if (w_rd_en) begin
            r_valid <= 1'b1;
            r_re    <= w_rd_word[2*DATA_W-1:DATA_W];
            r_im    <= w_rd_word[DATA_W-1:0];
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign bus.oValid   = r_valid;
    assign bus.oData_Re = r_re;
    assign bus.oData_Im = r_im;

`ifdef FFT_REORDER_FRAME_EN
    logic r_sof;
    logic r_eof;

    // Frame markers registered alongside the output sample.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_sof <= 1'b0;
            r_eof <= 1'b0;
        end else if (w_rd_en) begin
            r_sof <= (r_rd_cnt == CNT_ZERO);
            r_eof <= (r_rd_cnt == CNT_LAST);
        end else begin
            r_sof <= 1'b0;
            r_eof <= 1'b0;
        end
    end

    assign bus.oSof = r_sof;
    assign bus.oEof = r_eof;
`endif

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Bench for fft_bitrev_reorder: fixed table for the reference frame plus a cycle-accurate
// frame-level scoreboard checking every output cycle against the reordering rule.
module tb_fft_bitrev_reorder;
    localparam int DATA_W = 38;
    localparam int LOG2N  = 4;
    localparam int N      = 16;

    logic iClk = 1'b0;
    logic iRst = 1'b0;
    always #5 iClk = ~iClk;

    fft_bitrev_reorder_if #(.DATA_W(DATA_W)) bus ();

    fft_bitrev_reorder #(.DATA_W(DATA_W), .LOG2N(LOG2N)) dut (
        .iClk (iClk),
        .iRst (iRst),
        .bus  (bus.slave)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [2*DATA_W-1:0] act, input logic [2*DATA_W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic int rev(input int k);
        int r = 0;
        for (int b = 0; b < LOG2N; b++) r += ((k >> b) & 1) << (LOG2N - 1 - b);
        return r;
    endfunction

    // Scoreboard: each completed frame schedules N outputs on the N cycles after its last capture.
    typedef struct {
        logic [DATA_W-1:0] re;
        logic [DATA_W-1:0] im;
        int                cyc;
        int                idx;
    } exp_t;

    exp_t              exp_q[$];
    logic [2*DATA_W-1:0] part[$];
    int                cyc    = 0;
    bit                mon_en = 1'b0;

    always @(posedge iClk) begin
        cyc = cyc + 1;
        if (iRst) begin
            exp_q.delete();
            part.delete();
        end else if (bus.iEn) begin
            part.push_back({bus.iData_Re, bus.iData_Im});
            if (part.size() == N) begin
                for (int k = 0; k < N; k++) begin
                    exp_t e;
                    e.re  = part[rev(k)][2*DATA_W-1:DATA_W];
                    e.im  = part[rev(k)][DATA_W-1:0];
                    e.cyc = cyc + 1 + k;
                    e.idx = k;
                    exp_q.push_back(e);
                end
                part.delete();
            end
        end
    end

    always @(negedge iClk) begin
        if (mon_en && !iRst) begin
            logic exp_v;
            exp_v = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
            chk("mon_valid", bus.oValid, exp_v);
            if (exp_v) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("mon_re", bus.oData_Re, e.re);
                chk("mon_im", bus.oData_Im, e.im);
`ifdef FFT_REORDER_FRAME_EN
                chk("mon_sof", bus.oSof, (e.idx == 0));
                chk("mon_eof", bus.oEof, (e.idx == N - 1));
`endif
            end else begin
`ifdef FFT_REORDER_FRAME_EN
                chk("mon_sof_idle", bus.oSof, 1'b0);
                chk("mon_eof_idle", bus.oEof, 1'b0);
`endif
            end
        end
    end

    task automatic drive(input logic en, input logic [DATA_W-1:0] re, input logic [DATA_W-1:0] im);
        @(negedge iClk);
        bus.iEn      = en;
        bus.iData_Re = re;
        bus.iData_Im = im;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, bus.oValid, 1'b0);
        chk({tag, "_re"}, bus.oData_Re, '0);
        chk({tag, "_im"}, bus.oData_Im, '0);
`ifdef FFT_REORDER_FRAME_EN
        chk({tag, "_sof"}, bus.oSof, 1'b0);
        chk({tag, "_eof"}, bus.oEof, 1'b0);
`endif
    endtask

    // Asynchronous reset pulse between edges; outputs must clear with no clock edge.
    task automatic pulse_reset(input string tag);
        @(negedge iClk);
        bus.iEn = 1'b0;
        #1 iRst = 1'b1;
        #1 check_reset_outputs(tag);
        @(posedge iClk);
        @(negedge iClk);
        iRst = 1'b0;
    endtask

    task automatic drain(input string tag);
        int budget = 0;
        while (exp_q.size() > 0 && budget < 200) begin
            @(negedge iClk);
            budget++;
        end
        n_total++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL %s_drain_timeout: got %0d pending expected 0", tag, exp_q.size());
        repeat (3) @(negedge iClk);
    endtask

    function automatic logic [DATA_W-1:0] rnd();
        logic [63:0] v;
        v = {$urandom, $urandom};
        return v[DATA_W-1:0];
    endfunction

    typedef struct {
        logic [DATA_W-1:0] re_in;
        logic [DATA_W-1:0] im_in;
        logic [DATA_W-1:0] exp_re;
        logic [DATA_W-1:0] exp_im;
    } vec_t;

    vec_t tbl[N];
    int   exp_order[N];

    initial begin
        logic [DATA_W-1:0] t;
        exp_order = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
        for (int j = 0; j < N; j++) begin
            t = DATA_W'(j);
            tbl[j].re_in  = t;
            tbl[j].im_in  = ~t + {{(DATA_W-1){1'b0}}, 1'b1};
            t = DATA_W'(exp_order[j]);
            tbl[j].exp_re = t;
            tbl[j].exp_im = ~t + {{(DATA_W-1){1'b0}}, 1'b1};
        end

        bus.iEn = 1'b0;
        bus.iData_Re = '0;
        bus.iData_Im = '0;

        // T1: reset state
        #2 iRst = 1'b1;
        #2 check_reset_outputs("reset_async");
        repeat (2) @(posedge iClk);
        @(negedge iClk);
        check_reset_outputs("reset_held");
        iRst = 1'b0;
        mon_en = 1'b1;

        // T2: reference frame from the table
        for (int j = 0; j < N; j++) drive(1'b1, tbl[j].re_in, tbl[j].im_in);
        drive(1'b0, '0, '0);
        for (int k = 0; k < N; k++) begin
            @(negedge iClk);
            chk($sformatf("t2_valid[%0d]", k), bus.oValid, 1'b1);
            chk($sformatf("t2_re[%0d]", k), bus.oData_Re, tbl[k].exp_re);
            chk($sformatf("t2_im[%0d]", k), bus.oData_Im, tbl[k].exp_im);
        end
        @(negedge iClk);
        chk("t2_valid_end", bus.oValid, 1'b0);
        chk("t2_hold_re", bus.oData_Re, tbl[N-1].exp_re);
        drain("t2");

        // T3: three back-to-back frames
        for (int f = 0; f < 3; f++)
            for (int j = 0; j < N; j++) drive(1'b1, DATA_W'(f * 100 + j), rnd());
        drive(1'b0, '0, '0);
        drain("t3");

        // T4: alternating gaps
        for (int j = 0; j < N; j++) begin
            drive(1'b1, tbl[j].re_in, tbl[j].im_in);
            if (j != N - 1) drive(1'b0, rnd(), rnd());
        end
        drive(1'b0, '0, '0);
        drain("t4");

        // T5: reset at output index 5, then a fresh frame
        for (int j = 0; j < N; j++) drive(1'b1, DATA_W'(j + 50), DATA_W'(j + 70));
        drive(1'b0, '0, '0);
        repeat (5) @(negedge iClk);
        pulse_reset("t5_reset");
        for (int j = 0; j < N; j++) drive(1'b1, rnd(), rnd());
        drive(1'b0, '0, '0);
        drain("t5");

        // Partial frame discarded by reset
        for (int j = 0; j < 7; j++) drive(1'b1, rnd(), rnd());
        pulse_reset("partial_reset");
        for (int j = 0; j < N; j++) drive(1'b1, rnd(), rnd());
        drive(1'b0, '0, '0);
        drain("partial");

        // Randomized stream with random gaps and dense bursts
        for (int s = 0; s < 400; s++) begin
            logic en;
            en = (s >= 150 && s < 250) ? 1'b1 : ($urandom_range(0, 3) != 0);
            drive(en, rnd(), rnd());
        end
        drive(1'b0, '0, '0);
        drain("random");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
